// File: rtl/rgb_block_sequencer.sv
// Walks a raster-stored RGB frame in 8x8 block order, drives the converter one pixel at a time,
// fills a 64-entry block buffer and hands each finished block downstream with valid/ready.
module rgb_block_sequencer #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic              conv_start,
    output logic [7:0]        conv_r,
    output logic [7:0]        conv_g,
    output logic [7:0]        conv_b,
    input  logic [7:0]        conv_y,
    input  logic [7:0]        conv_cb,
    input  logic [7:0]        conv_cr,
    input  logic              conv_done,
    output logic              buf_we,
    output logic [5:0]        buf_addr,
    output logic [23:0]       buf_wdata,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [7:0]        blk_x,
    output logic [7:0]        blk_y,
    output logic              busy,
    output logic              frame_done
);

    localparam int BLK_COLS = IMG_W / 8;
    localparam int BLK_ROWS = IMG_H / 8;
    localparam int BX_W     = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
    localparam int BY_W     = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;

    typedef enum logic [2:0] {IDLE, RD, LATCH, START, WAIT, WR, BLK, FIN} state_t;

    state_t          state;
    logic [2:0]      px, py;
    logic [BX_W-1:0] bx;
    logic [BY_W-1:0] by;

    logic [2:0]      px_next, py_next;
    logic [BX_W-1:0] bx_next;
    logic [BY_W-1:0] by_next;
    logic            bx_last, by_last, pix_last;

    // Raster address of pixel (px,py) inside block (bx,by), truncated to the memory width.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [BY_W-1:0] b_y, input logic [2:0] p_y,
                                                   input logic [BX_W-1:0] b_x, input logic [2:0] p_x);
        logic [31:0] row, col;
        row = 32'(b_y) * 32'd8 + 32'(p_y);
        col = 32'(b_x) * 32'd8 + 32'(p_x);
        return ADDR_W'(row * 32'(IMG_W) + col);
    endfunction

    always_comb begin
        px_next  = px + 3'd1;
        py_next  = (px == 3'd7) ? py + 3'd1 : py;
        pix_last = (px == 3'd7) && (py == 3'd7);
        bx_last  = (bx == BX_W'(BLK_COLS - 1));
        by_last  = (by == BY_W'(BLK_ROWS - 1));
        bx_next  = bx_last ? '0 : bx + BX_W'(1);
        by_next  = bx_last ? (by_last ? '0 : by + BY_W'(1)) : by;
    end

    assign blk_x = 8'(bx);
    assign blk_y = 8'(by);

    // Outputs are registered on the transition into the state that owns them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            px         <= '0;
            py         <= '0;
            bx         <= '0;
            by         <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            conv_start <= 1'b0;
            conv_r     <= '0;
            conv_g     <= '0;
            conv_b     <= '0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= '0;
            blk_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        px       <= '0;
                        py       <= '0;
                        bx       <= '0;
                        by       <= '0;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= '0;
                        state    <= RD;
                    end
                end
                RD: begin
                    mem_rd <= 1'b0;
                    state  <= LATCH;
                end
                LATCH: begin
                    conv_r     <= mem_rdata[23:16];
                    conv_g     <= mem_rdata[15:8];
                    conv_b     <= mem_rdata[7:0];
                    conv_start <= 1'b1;
                    state      <= START;
                end
                START: begin
                    conv_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (conv_done) begin
                        buf_we    <= 1'b1;
                        buf_addr  <= {py, px};
                        buf_wdata <= {conv_y, conv_cb, conv_cr};
                        state     <= WR;
                    end
                end
                WR: begin
                    buf_we <= 1'b0;
                    if (pix_last) begin
                        blk_valid <= 1'b1;
                        state     <= BLK;
                    end else begin
                        px       <= px_next;
                        py       <= py_next;
                        mem_rd   <= 1'b1;
                        mem_addr <= pix_addr(by, py_next, bx, px_next);
                        state    <= RD;
                    end
                end
                BLK: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        px        <= '0;
                        py        <= '0;
                        bx        <= bx_next;
                        by        <= by_next;
                        if (bx_last && by_last) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= FIN;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= pix_addr(by_next, 3'd0, bx_next, 3'd0);
                            state    <= RD;
                        end
                    end
                end
                FIN: begin
                    frame_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_block_sequencer.sv
// Bench for rgb_block_sequencer on a 16x16 frame: memory and converter models, a passive monitor,
// and a directed sequence of frames checked against the raster/block ordering rules.
module tb_rgb_block_sequencer;

    localparam int W    = 16;
    localparam int H    = 16;
    localparam int AW   = 8;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_n, frame_start, blk_ready;
    logic          mem_rd, conv_start, buf_we, blk_valid, busy, frame_done;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_rdata = '0;
    logic [7:0]    conv_r, conv_g, conv_b;
    logic [7:0]    conv_y = '0, conv_cb = '0, conv_cr = '0;
    logic          model_done = 1'b0, spur_done;
    wire logic     conv_done = model_done | spur_done;
    logic [5:0]    buf_addr;
    logic [23:0]   buf_wdata;
    logic [7:0]    blk_x, blk_y;

    rgb_block_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .conv_start(conv_start), .conv_r(conv_r), .conv_g(conv_g), .conv_b(conv_b),
        .conv_y(conv_y), .conv_cb(conv_cb), .conv_cr(conv_cr), .conv_done(conv_done),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_x(blk_x), .blk_y(blk_y),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [0:NPIX-1];
    int          conv_delay = 3;
    int          cyc = 0;
    int          checks = 0, errors = 0;

    logic [7:0]  rd_q[$];
    int          rd_cyc_q[$];
    logic [29:0] we_q[$];
    logic [15:0] blk_q[$];
    int          blk_cyc_q[$], hs_cyc_q[$], fd_cyc_q[$];
    int          start_cnt = 0, stall_viol = 0, busy_viol = 0;
    int          stab_viol = 0, overlap_viol = 0;

    function automatic logic [23:0] conv_fn(input logic [23:0] rgb);
        logic [7:0] r, g, b;
        {r, g, b} = rgb;
        return {r ^ g, g + b, r - b};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    // Converter: samples RGB the cycle after start, answers conv_delay cycles after start (random if 0).
    initial forever begin
        @(posedge clk); #1;
        if (rst_n && conv_start) begin
            int          d;
            logic [23:0] rgb;
            bit          aborted;
            d = (conv_delay > 0) ? conv_delay : int'($urandom_range(8, 2));
            @(posedge clk); #1;
            rgb     = {conv_r, conv_g, conv_b};
            aborted = !rst_n;
            if (conv_start) overlap_viol++;
            for (int k = 1; k < d && !aborted; k++) begin
                @(posedge clk); #1;
                if (!rst_n) aborted = 1;
                else begin
                    if ({conv_r, conv_g, conv_b} !== rgb) stab_viol++;
                    if (conv_start) overlap_viol++;
                end
            end
            if (!aborted) begin
                {conv_y, conv_cb, conv_cr} = conv_fn(rgb);
                model_done = 1'b1;
                @(posedge clk); #1;
                model_done = 1'b0;
            end
        end
    end

    initial begin
        logic blk_prev;
        blk_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_rd) begin
                    rd_q.push_back(mem_addr);
                    rd_cyc_q.push_back(cyc);
                end
                if (buf_we) we_q.push_back({buf_addr, buf_wdata});
                if (conv_start) start_cnt++;
                if (blk_valid && !blk_prev) begin
                    blk_q.push_back({blk_x, blk_y});
                    blk_cyc_q.push_back(cyc);
                end
                if (blk_valid && blk_ready) hs_cyc_q.push_back(cyc);
                if (blk_valid && (mem_rd || buf_we)) stall_viol++;
                if (frame_done) begin
                    fd_cyc_q.push_back(cyc);
                    if (busy) busy_viol++;
                end
            end
            blk_prev = blk_valid;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {mem_rd, conv_start, buf_we, blk_valid, busy, frame_done,
                             mem_addr, buf_addr, blk_x, blk_y}, 64'd0);
        chk({tag, "_data"}, {conv_r, conv_g, conv_b, buf_wdata}, 64'd0);
    endtask

    // sel: 0 frame_done, 1 mem_rd, 2 blk_valid, 3 buffer write count reaches target
    task automatic wait_until(input int sel, input int target, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk); #1;
            case (sel)
                0:       ok = (frame_done === 1'b1);
                1:       ok = (mem_rd === 1'b1);
                2:       ok = (blk_valid === 1'b1);
                default: ok = (we_q.size() >= target);
            endcase
        end
    endtask

    // Expected order: blocks left-to-right then top-to-bottom, pixels raster order inside a block.
    task automatic check_frame(input int rb, input int wb, input int bb);
        chk("rd_count", rd_q.size() - rb, NPIX);
        chk("we_count", we_q.size() - wb, NPIX);
        chk("blk_count", blk_q.size() - bb, NPIX / 64);
        for (int k = 0; k < NPIX; k++) begin
            int blk, i, bx, by, a;
            blk = k / 64;
            i   = k % 64;
            bx  = blk % (W / 8);
            by  = blk / (W / 8);
            a   = (by * 8 + i / 8) * W + bx * 8 + i % 8;
            if (rb + k < rd_q.size()) chk("rd_addr", rd_q[rb + k], a);
            if (wb + k < we_q.size()) begin
                chk("buf_addr", we_q[wb + k][29:24], i);
                chk("buf_data", we_q[wb + k][23:0], conv_fn(mem[a]));
            end
            if (i == 0 && bb + blk < blk_q.size()) chk("blk_xy", blk_q[bb + blk], {8'(bx), 8'(by)});
        end
    endtask

    initial begin
        bit ok;
        int rb, wb, bb, hb, sb, t0, fd0;

        rst_n = 1'b0; frame_start = 1'b0; blk_ready = 1'b1; spur_done = 1'b0;
        for (int i = 0; i < NPIX; i++) mem[i] = 24'($urandom());
        repeat (3) @(posedge clk); #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Frame 1: converter answers 3 cycles after start, blk_ready held high.
        rb = rd_q.size(); wb = we_q.size(); bb = blk_q.size(); hb = hs_cyc_q.size(); sb = start_cnt;
        frame_start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("f1_first_rd", {busy, mem_rd, mem_addr}, {2'b11, 8'd0});
        wait_until(0, 0, 4000, ok);
        chk("f1_done_seen", ok, 1);
        chk("f1_busy_in_fin", busy, 0);
        check_frame(rb, wb, bb);
        chk("f1_addr8", rd_q[rb + 8], 16);
        chk("f1_blk1_addr", rd_q[rb + 64], 8);
        chk("f1_blk2_addr", rd_q[rb + 128], 128);
        if (blk_cyc_q.size() >= bb + 4 && hs_cyc_q.size() > hb) begin
            chk("f1_blk0_latency", blk_cyc_q[bb] - t0, 449);
            chk("f1_blk0_one_cycle", hs_cyc_q[hb], blk_cyc_q[bb]);
            chk("f1_resume_rd", rd_cyc_q[rb + 64], blk_cyc_q[bb] + 1);
            chk("f1_done_after_blk", cyc, blk_cyc_q[bb + 3] + 1);
        end
        chk("f1_starts", start_cnt - sb, NPIX);

        // frame_start in the FIN cycle is ignored; held into IDLE it is accepted.
        frame_start = 1'b1; blk_ready = 1'b0; conv_delay = 10;
        @(posedge clk); #1;
        chk("fin_start_ignored", {busy, mem_rd}, 2'b00);
        rb = rd_q.size(); wb = we_q.size(); bb = blk_q.size(); sb = start_cnt;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("f2_start_after_fin", {busy, mem_rd, mem_addr}, {2'b11, 8'd0});

        // Frame 2: slow converter, spurious frame_start and conv_done, then backpressure.
        repeat (40) @(posedge clk); #1;
        wait_until(1, 0, 100, ok);
        chk("f2_rd_seen", ok, 1);
        spur_done = 1'b1; frame_start = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0; frame_start = 1'b0;
        wait_until(2, 0, 2000, ok);
        chk("f2_blk_seen", ok, 1);
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", blk_valid, 1);
            chk("stall_no_rd_we", {mem_rd, buf_we}, 2'b00);
            chk("stall_xy", {blk_x, blk_y}, 16'h0000);
            @(posedge clk); #1;
        end
        blk_ready = 1'b1;
        @(posedge clk); #1;
        chk("f2_resume", {blk_valid, mem_rd, mem_addr, blk_x}, {2'b01, 8'd8, 8'd1});
        wait_until(0, 0, 6000, ok);
        chk("f2_done_seen", ok, 1);
        check_frame(rb, wb, bb);
        chk("f2_starts", start_cnt - sb, NPIX);
        chk("conv_rgb_stable", stab_viol, 0);
        chk("conv_no_overlap", overlap_viol, 0);
        chk("stall_monitor", stall_viol, 0);

        // Frame 3: random converter latency, aborted by reset after pixel 30.
        conv_delay = 0;
        repeat (2) @(posedge clk); #1;
        wb = we_q.size(); fd0 = fd_cyc_q.size();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        wait_until(3, wb + 31, 2000, ok);
        chk("f3_pixel30_seen", ok, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (5) @(posedge clk); #1;
        chk("abort_no_done", fd_cyc_q.size(), fd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Frame 4: restart after the abort, random converter latency.
        rb = rd_q.size(); wb = we_q.size(); bb = blk_q.size(); sb = start_cnt;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        wait_until(0, 0, 8000, ok);
        chk("f4_done_seen", ok, 1);
        if (rd_q.size() > rb) chk("f4_first_addr", rd_q[rb], 0);
        if (we_q.size() > wb) chk("f4_first_buf_addr", we_q[wb][29:24], 0);
        check_frame(rb, wb, bb);
        chk("f4_starts", start_cnt - sb, NPIX);
        chk("conv_rgb_stable_end", stab_viol, 0);
        chk("conv_no_overlap_end", overlap_viol, 0);
        chk("stall_monitor_end", stall_viol, 0);
        chk("busy_low_at_done", busy_viol, 0);
        @(posedge clk); #1;
        chk("idle_after_frame", {busy, frame_done, mem_rd}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
